// File: rtl/hub75_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hub75_scan_ctrl
// Description : Scan sequencer for a 32x16 HUB75 RGB panel. Reads one row
//               pair of a double-buffered screen memory, shifts it into the
//               panel, blanks, latches, then displays it while the next row
//               pair is being shifted. Front/back buffer swaps are taken only
//               at the frame boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module hub75_scan_ctrl #(
    parameter int COLS      = 32,
    parameter int ROWS      = 8,
    parameter int CLKDIV    = 2,
    parameter int BLANK_CYC = 4,
    parameter int ON_CYC    = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      swap_req,
    input  logic [5:0]                pix_data,
    output logic [$clog2(COLS)-1:0]   rd_col,
    output logic [$clog2(ROWS)-1:0]   rd_row,
    output logic                      buf_sel,
    output logic                      swap_done,
    output logic [5:0]                rgb,
    output logic                      outclk,
    output logic                      lat,
    output logic                      oe,
    output logic [$clog2(ROWS)-1:0]   abc
);

    localparam int CW   = $clog2(COLS);
    localparam int RW   = $clog2(ROWS);
    localparam int PW   = $clog2(2 * CLKDIV);
    localparam int NMAX = (BLANK_CYC > ON_CYC) ? BLANK_CYC : ON_CYC;
    localparam int NW   = $clog2(NMAX + 1);

    localparam logic [PW-1:0] PH_LAST    = PW'(2 * CLKDIV - 1);
    localparam logic [PW-1:0] PH_RISE    = PW'(CLKDIV);
    localparam logic [PW-1:0] PH_LOAD    = PW'(1);
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [NW-1:0] BLANK_LAST = NW'(BLANK_CYC - 1);
    localparam logic [NW-1:0] ON_LAST    = NW'(ON_CYC - 1);

    typedef enum logic [1:0] {
        S_SHIFT   = 2'd0,
        S_BLANK   = 2'd1,
        S_LATCH   = 2'd2,
        S_DISPLAY = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   ph;
    logic [CW-1:0]   col;
    logic [NW-1:0]   cnt;
    logic [RW-1:0]   shift_row;
    logic            lit;
    logic            shift_last;

    // Screen memory is addressed straight from the scan counters so the
    // 1-cycle read lands in time for the load phase (ph=1).
    assign rd_col = col;
    assign rd_row = shift_row;

    // Pin decodes; oe keeps the previously latched row lit while shifting.
    assign outclk = (state == S_SHIFT) && (ph >= PH_RISE);
    assign lat    = (state == S_LATCH);
    assign oe     = (state == S_SHIFT)   ? ~lit :
                    (state == S_DISPLAY) ? 1'b0 : 1'b1;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_SHIFT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: SHIFT -> BLANK -> LATCH -> DISPLAY -> SHIFT.
    always_comb begin
        state_next = state;
        shift_last = (col == COL_LAST) && (ph == PH_LAST);
        case (state)
            S_SHIFT:   if (shift_last)        state_next = S_BLANK;
            S_BLANK:   if (cnt == BLANK_LAST) state_next = S_LATCH;
            S_LATCH:                          state_next = S_DISPLAY;
            S_DISPLAY: if (cnt == ON_LAST)    state_next = S_SHIFT;
            default:                          state_next = S_SHIFT;
        endcase
    end

    // Scan counters, pixel/row registers and the frame-boundary buffer swap.
    always_ff @(posedge clk) begin
        if (reset) begin
            ph        <= '0;
            col       <= '0;
            cnt       <= '0;
            shift_row <= '0;
            lit       <= 1'b0;
            rgb       <= '0;
            abc       <= '0;
            buf_sel   <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            swap_done <= 1'b0;
            case (state)
                S_SHIFT: begin
                    cnt <= '0;
                    if (ph == PH_LAST) begin
                        ph  <= '0;
                        col <= shift_last ? '0 : col + 1'b1;
                    end else begin
                        ph <= ph + 1'b1;
                    end
                    if (ph == PH_LOAD) begin
                        rgb <= pix_data;
                    end
                end
                S_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        cnt <= '0;
                        // Row address moves while dark, so it is valid
                        // throughout the latch pulse.
                        abc <= shift_row;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_LATCH: begin
                    lit       <= 1'b1;
                    shift_row <= (shift_row == ROW_LAST) ? '0 : shift_row + 1'b1;
                    // Only the last row's latch is a frame boundary; a swap
                    // here is seen by row 0 of the next frame.
                    if ((shift_row == ROW_LAST) && swap_req) begin
                        buf_sel   <= ~buf_sel;
                        swap_done <= 1'b1;
                    end
                end
                S_DISPLAY: begin
                    cnt <= (cnt == ON_LAST) ? '0 : cnt + 1'b1;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hub75_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hub75_scan_ctrl
// Description : Scoreboard bench for hub75_scan_ctrl. The stimulus process
//               drives reset/swap_req, owns a screen-memory model, and pushes
//               expected shift/latch/swap events computed from the row and
//               frame timing; a negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hub75_scan_ctrl;

    localparam int COLS      = 32;
    localparam int ROWS      = 8;
    localparam int CLKDIV    = 2;
    localparam int BLANK_CYC = 4;
    localparam int ON_CYC    = 64;
    localparam int SHIFT_CYC = COLS * 2 * CLKDIV;               // 128
    localparam int LAT_OFF   = SHIFT_CYC + BLANK_CYC;           // 132
    localparam int ROW_CYC   = SHIFT_CYC + BLANK_CYC + 1 + ON_CYC; // 197
    localparam int FRAME_CYC = ROW_CYC * ROWS;                  // 1576
    localparam logic [21:0] RST_EXP = 22'd1 << 13;              // only oe high

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       swap_req = 1'b0;
    logic [5:0] pix_data = 6'd0;
    logic [4:0] rd_col;
    logic [2:0] rd_row;
    logic       buf_sel;
    logic       swap_done;
    logic [5:0] rgb;
    logic       outclk;
    logic       lat;
    logic       oe;
    logic [2:0] abc;

    hub75_scan_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .CLKDIV(CLKDIV),
        .BLANK_CYC(BLANK_CYC), .ON_CYC(ON_CYC)
    ) dut (
        .clk(clk), .reset(reset), .swap_req(swap_req), .pix_data(pix_data),
        .rd_col(rd_col), .rd_row(rd_row), .buf_sel(buf_sel),
        .swap_done(swap_done), .rgb(rgb), .outclk(outclk), .lat(lat),
        .oe(oe), .abc(abc)
    );

    always #5 clk = ~clk;

    // Double-buffered screen memory with a registered (1-cycle) read.
    logic [5:0] mem [2][ROWS][COLS];
    always @(posedge clk) pix_data <= mem[buf_sel][rd_row][rd_col];

    typedef struct { int t; logic [5:0] v; } rise_t;
    typedef struct { int t; int abc; }      lat_t;
    typedef struct { int t; int b; }        swap_t;
    rise_t rise_q[$];
    lat_t  lat_q[$];
    swap_t swap_q[$];

    int checks = 0;
    int errors = 0;
    int mcyc   = -1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, mcyc);
        end
    endtask

    // Output-enable is dark through the first SHIFT after reset, dark in
    // blank and latch, lit in display and in every later SHIFT.
    function automatic int exp_oe(input int t);
        int off;
        off = t % ROW_CYC;
        if (off >= SHIFT_CYC && off <= LAT_OFF) return 1;
        if (off > LAT_OFF) return 0;
        return (t < ROW_CYC) ? 1 : 0;
    endfunction

    // Any expectation dated before 'now' that is still queued never happened.
    task automatic check_pending(input int now);
        while (rise_q.size() > 0 && rise_q[0].t < now) begin
            check("missed_rise", 0, 1);
            void'(rise_q.pop_front());
        end
        while (lat_q.size() > 0 && lat_q[0].t < now) begin
            check("missed_lat", 0, 1);
            void'(lat_q.pop_front());
        end
        while (swap_q.size() > 0 && swap_q[0].t < now) begin
            check("missed_swap", 0, 1);
            void'(swap_q.pop_front());
        end
    endtask

    // Assert reset for three edges, refresh memory, drop expectations.
    task automatic do_reset(input int now);
        reset    = 1'b1;
        swap_req = 1'b0;
        check_pending(now);
        rise_q.delete();
        lat_q.delete();
        swap_q.delete();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    mem[b][r][c] = 6'($urandom);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Run ncyc cycles from reset release. mode 0: no request; 1: raise
    // swap_req at req_at and drop it after swap_done; 2: raise and hold.
    task automatic run(input int ncyc, input int mode, input int req_at);
        int    front;
        int    k, off, row;
        rise_t re;
        lat_t  le;
        swap_t se;
        front = 0;
        for (int t = 0; t < ncyc; t++) begin
            if (mode != 0 && t == req_at)
                swap_req = 1'b1;
            else if (mode == 1 && swap_req && swap_done)
                swap_req = 1'b0;
            k   = t / ROW_CYC;
            off = t % ROW_CYC;
            row = k % ROWS;
            if (off == 0) begin
                for (int c = 0; c < COLS; c++) begin
                    re.t = t + c * 2 * CLKDIV + CLKDIV;
                    re.v = mem[front][row][c];
                    rise_q.push_back(re);
                end
                le.t   = t + LAT_OFF;
                le.abc = row;
                lat_q.push_back(le);
            end
            if (off == LAT_OFF && row == ROWS - 1 && swap_req) begin
                front ^= 1;
                se.t = t + 1;
                se.b = front;
                swap_q.push_back(se);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: samples on the falling edge, pops expectations on events.
    initial begin : monitor
        bit         prev_rst;
        logic       prev_outclk;
        logic [2:0] prev_abc;
        logic [21:0] got;
        rise_t r;
        lat_t  l;
        swap_t s;
        prev_rst    = 1'b0;
        prev_outclk = 1'b0;
        prev_abc    = 3'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (prev_rst) begin
                    got = {rgb, outclk, lat, oe, abc, rd_col, rd_row, buf_sel, swap_done};
                    check("reset_state", int'(got), int'(RST_EXP));
                end
                prev_rst    = 1'b1;
                mcyc        = -1;
                prev_outclk = 1'b0;
                prev_abc    = 3'd0;
            end else begin
                prev_rst = 1'b0;
                mcyc++;
                check("oe", int'(oe), exp_oe(mcyc));
                check("lat_outclk_overlap", int'(lat & outclk), 0);
                if (abc != prev_abc)
                    check("abc_change_outside_latch", int'(lat), 1);
                if (outclk && !prev_outclk) begin
                    if (rise_q.size() == 0) check("unexpected_rise", 1, 0);
                    else begin
                        r = rise_q.pop_front();
                        check("rise_time", mcyc, r.t);
                        check("rise_rgb", int'(rgb), int'(r.v));
                    end
                end
                if (lat) begin
                    if (lat_q.size() == 0) check("unexpected_lat", 1, 0);
                    else begin
                        l = lat_q.pop_front();
                        check("lat_time", mcyc, l.t);
                        check("lat_abc", int'(abc), l.abc);
                    end
                end
                if (swap_done) begin
                    if (swap_q.size() == 0) check("unexpected_swap_done", 1, 0);
                    else begin
                        s = swap_q.pop_front();
                        check("swap_time", mcyc, s.t);
                        check("swap_buf_sel", int'(buf_sel), s.b);
                    end
                end
                prev_outclk = outclk;
                prev_abc    = abc;
            end
        end
    end

    // Stimulus sequence.
    initial begin : stim
        int n;
        do_reset(0);
        // Idle free run over two frames.
        n = 2 * FRAME_CYC + 100;
        run(n, 0, 0);
        do_reset(n);
        // Request raised during row 3, handshake drops it after swap_done.
        run(n, 1, 3 * ROW_CYC + int'($urandom_range(0, ROW_CYC - 1)));
        do_reset(n);
        // Request held across two boundaries.
        n = 2 * FRAME_CYC + 300;
        run(n, 2, int'($urandom_range(0, 100)));
        do_reset(n);
        // Reset mid-SHIFT, then reset during a LATCH clock, then a short run.
        n = 2 * ROW_CYC + int'($urandom_range(0, SHIFT_CYC - 1));
        run(n, 0, 0);
        do_reset(n);
        n = ROW_CYC + LAT_OFF;
        run(n, 0, 0);
        do_reset(n);
        n = 600;
        run(n, 0, 0);
        do_reset(n);
        // Randomized runs.
        for (int i = 0; i < 3; i++) begin
            n = int'($urandom_range(FRAME_CYC + 200, 2 * FRAME_CYC + 300));
            run(n, int'($urandom_range(0, 2)), int'($urandom_range(0, FRAME_CYC)));
            do_reset(n);
        end
        run(10, 0, 0);
        check_pending(10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
